// File: rtl/status_reg.sv
// 6502 processor status (P) register: ALU flag capture, flag instructions,
// PLP/RTI loads, push formatting and the one-cycle-late interrupt mask.
module status_reg #(
    parameter logic [7:0] RESET_FLAGS = 8'b0011_0100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       alu_c_out,
    input  logic [3:0] alu_flag_en,
    input  logic [2:0] flag_op,
    input  logic       load_en,
    input  logic [7:0] load_data,
    input  logic       irq_entry,
    input  logic       push_brk,
    output logic [7:0] p,
    output logic [7:0] p_push,
    output logic       c_flag,
    output logic       bcd,
    output logic       irq_mask
);

    localparam logic [2:0] OP_CLC = 3'd1;
    localparam logic [2:0] OP_SEC = 3'd2;
    localparam logic [2:0] OP_CLI = 3'd3;
    localparam logic [2:0] OP_SEI = 3'd4;
    localparam logic [2:0] OP_CLV = 3'd5;
    localparam logic [2:0] OP_CLD = 3'd6;
    localparam logic [2:0] OP_SED = 3'd7;

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic irq_mask_q, irq_mask_d;

    // Bits 5/4 of a popped byte have no storage; they are dropped on load.
    logic unused_load_bits;
    assign unused_load_bits = ^load_data[5:4];

    always_comb begin
        n_d        = n_q;
        v_d        = v_q;
        d_d        = d_q;
        i_d        = i_q;
        z_d        = z_q;
        c_d        = c_q;
        irq_mask_d = i_q;

        // Lowest priority first; later assignments override earlier ones.
        if (alu_flag_en[0]) c_d = alu_c_out;
        if (alu_flag_en[1]) z_d = alu_zero;
        if (alu_flag_en[2]) v_d = alu_overflow;
        if (alu_flag_en[3]) n_d = alu_negative;

        case (flag_op)
            OP_CLC:  c_d = 1'b0;
            OP_SEC:  c_d = 1'b1;
            OP_CLI:  i_d = 1'b0;
            OP_SEI:  i_d = 1'b1;
            OP_CLV:  v_d = 1'b0;
            OP_CLD:  d_d = 1'b0;
            OP_SED:  d_d = 1'b1;
            default: ;
        endcase

        if (irq_entry) i_d = 1'b1;

        if (load_en) begin
            n_d = load_data[7];
            v_d = load_data[6];
            d_d = load_data[3];
            i_d = load_data[2];
            z_d = load_data[1];
            c_d = load_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q        <= RESET_FLAGS[7];
            v_q        <= RESET_FLAGS[6];
            d_q        <= RESET_FLAGS[3];
            i_q        <= RESET_FLAGS[2];
            z_q        <= RESET_FLAGS[1];
            c_q        <= RESET_FLAGS[0];
            irq_mask_q <= 1'b1;
        end else begin
            n_q        <= n_d;
            v_q        <= v_d;
            d_q        <= d_d;
            i_q        <= i_d;
            z_q        <= z_d;
            c_q        <= c_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    // p_push reflects pre-update state so BRK pushes I before irq_entry sets it.
    assign p        = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    assign p_push   = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
    assign c_flag   = c_q;
    assign bcd      = d_q;
    assign irq_mask = irq_mask_q;

endmodule

// File: tb/tb_status_reg.sv
// Bench for status_reg: byte-level reference model checked every cycle,
// plus hand-computed P values along a directed instruction sequence.
module tb_status_reg;

    logic       clk;
    logic       reset;
    logic       alu_zero, alu_negative, alu_overflow, alu_c_out;
    logic [3:0] alu_flag_en;
    logic [2:0] flag_op;
    logic       load_en;
    logic [7:0] load_data;
    logic       irq_entry;
    logic       push_brk;
    logic [7:0] p, p_push;
    logic       c_flag, bcd, irq_mask;

    int checks   = 0;
    int failures = 0;

    status_reg dut (
        .clk          (clk),
        .reset        (reset),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .alu_c_out    (alu_c_out),
        .alu_flag_en  (alu_flag_en),
        .flag_op      (flag_op),
        .load_en      (load_en),
        .load_data    (load_data),
        .irq_entry    (irq_entry),
        .push_brk     (push_brk),
        .p            (p),
        .p_push       (p_push),
        .c_flag       (c_flag),
        .bcd          (bcd),
        .irq_mask     (irq_mask)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole P byte as the program sees it.
    logic [7:0] m_p;
    logic       m_mask;
    logic       model_valid = 1'b0;

    always @(posedge clk) begin
        logic [7:0] nxt, alu_byte, en_byte;
        if (reset) begin
            m_p         = 8'h34;
            m_mask      = 1'b1;
            model_valid = 1'b1;
        end else if (model_valid) begin
            nxt      = m_p;
            alu_byte = {alu_negative, alu_overflow, 4'b0000, alu_zero, alu_c_out};
            en_byte  = {alu_flag_en[3], alu_flag_en[2], 4'b0000, alu_flag_en[1], alu_flag_en[0]};
            nxt      = (nxt & ~en_byte) | (alu_byte & en_byte);
            case (flag_op)
                3'd1: nxt[0] = 1'b0;
                3'd2: nxt[0] = 1'b1;
                3'd3: nxt[2] = 1'b0;
                3'd4: nxt[2] = 1'b1;
                3'd5: nxt[6] = 1'b0;
                3'd6: nxt[3] = 1'b0;
                3'd7: nxt[3] = 1'b1;
                default: ;
            endcase
            if (irq_entry) nxt[2] = 1'b1;
            if (load_en) nxt = load_data | 8'h30;
            m_mask = m_p[2];
            m_p    = nxt;
        end
    end

    // compare process
    always @(negedge clk) begin
        if (model_valid) begin
            check("p", p, m_p);
            check("p_push", p_push, {m_p[7:5], push_brk, m_p[3:0]});
            check("c_flag", {7'd0, c_flag}, {7'd0, m_p[0]});
            check("bcd", {7'd0, bcd}, {7'd0, m_p[3]});
            check("irq_mask", {7'd0, irq_mask}, {7'd0, m_mask});
        end
    end

    // driver tasks
    task automatic set_in(input logic rst, input logic [3:0] fe, input logic [2:0] fop,
                          input logic le, input logic [7:0] ld, input logic ie, input logic pb,
                          input logic an, input logic av, input logic az, input logic ac);
        reset        = rst;
        alu_flag_en  = fe;
        flag_op      = fop;
        load_en      = le;
        load_data    = ld;
        irq_entry    = ie;
        push_brk     = pb;
        alu_negative = an;
        alu_overflow = av;
        alu_zero     = az;
        alu_c_out    = ac;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input logic rst, input logic [3:0] fe, input logic [2:0] fop,
                        input logic le, input logic [7:0] ld, input logic ie, input logic pb,
                        input logic an, input logic av, input logic az, input logic ac);
        set_in(rst, fe, fop, le, ld, ie, pb, an, av, az, ac);
        tick();
    endtask

    task automatic idle();
        step(0, 4'h0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        set_in(1, 4'h0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tick();
        // reset
        step(1, 4'h0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        check("lit_reset_p", p, 8'h34);
        check("lit_reset_c", {7'd0, c_flag}, 8'h00);
        check("lit_reset_bcd", {7'd0, bcd}, 8'h00);
        check("lit_reset_mask", {7'd0, irq_mask}, 8'h01);
        for (int i = 0; i < 5; i++) idle();
        check("lit_idle_p", p, 8'h34);

        // ALU capture
        step(0, 4'hF, 3'd0, 0, 8'h00, 0, 0, 1, 1, 0, 1);
        check("lit_alu_all", p, 8'hF5);
        step(0, 4'h2, 3'd0, 0, 8'h00, 0, 0, 0, 0, 1, 0);
        check("lit_alu_z", p, 8'hF7);

        // flag ops and mask latency
        step(0, 4'h0, 3'd7, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        check("lit_sed", p, 8'hFF);
        check("lit_sed_bcd", {7'd0, bcd}, 8'h01);
        step(0, 4'h0, 3'd3, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        check("lit_cli_p", p, 8'hFB);
        check("lit_cli_mask_old", {7'd0, irq_mask}, 8'h01);
        idle();
        check("lit_cli_mask_new", {7'd0, irq_mask}, 8'h00);
        step(0, 4'h0, 3'd4, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        check("lit_sei_p", p, 8'hFF);
        check("lit_sei_mask_old", {7'd0, irq_mask}, 8'h00);
        idle();
        check("lit_sei_mask_new", {7'd0, irq_mask}, 8'h01);

        // PLP load beats CLC and ALU capture
        step(0, 4'hF, 3'd1, 1, 8'hC3, 0, 0, 0, 0, 0, 0);
        check("lit_plp_p", p, 8'hF3);
        check("lit_plp_c", {7'd0, c_flag}, 8'h01);

        // simultaneous events on different bits
        step(0, 4'h9, 3'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        check("lit_clear_nc", p, 8'h72);
        step(0, 4'h9, 3'd2, 0, 8'h00, 0, 0, 1, 0, 0, 0);
        check("lit_sec_alu", p, 8'hF3);

        // BRK: push shows old I, then I set, then mask follows
        set_in(0, 4'h0, 3'd0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        #1;
        check("lit_brk_push", p_push, 8'hF3);
        tick();
        check("lit_brk_p", p, 8'hF7);
        check("lit_brk_mask_old", {7'd0, irq_mask}, 8'h00);
        idle();
        check("lit_brk_mask_new", {7'd0, irq_mask}, 8'h01);
        check("lit_irq_push", p_push, 8'hE7);

        // irq_entry over CLI; remaining flag ops
        step(0, 4'h0, 3'd3, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        check("lit_ie_over_cli", p, 8'hF7);
        step(0, 4'h0, 3'd5, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        check("lit_clv", p, 8'hB7);
        step(0, 4'h0, 3'd7, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        step(0, 4'h0, 3'd6, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        check("lit_cld", p, 8'hB7);
        step(0, 4'h0, 3'd1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        check("lit_clc", p, 8'hB6);

        // load beats irq_entry; reset discards a pending load
        step(0, 4'h0, 3'd0, 1, 8'h00, 1, 0, 0, 0, 0, 0);
        check("lit_load_over_ie", p, 8'h30);
        step(1, 4'hF, 3'd7, 1, 8'hFF, 1, 0, 1, 1, 1, 1);
        check("lit_reset_mid", p, 8'h34);
        check("lit_reset_mid_mask", {7'd0, irq_mask}, 8'h01);

        // a short burst of mixed traffic checked by the model only
        for (int i = 0; i < 40; i++) begin
            step(0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
